// File: rtl/forwarding_scoreboard.sv
// Operand forwarding from NUM_WB writeback ports combined with a per-register
// scoreboard that stalls operands whose multi-cycle producer has not yet written back.
module forwarding_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_WB     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LAT_WIDTH  = 4,
    parameter int PORT_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]               src_float,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_data,
    input  logic [NUM_WB-1:0]                wb_enable,
    input  logic [NUM_WB*ADDR_WIDTH-1:0]     wb_addr,
    input  logic [NUM_WB-1:0]                wb_float,
    input  logic [NUM_WB*DATA_WIDTH-1:0]     wb_data,
    input  logic                             issue_valid,
    input  logic [ADDR_WIDTH-1:0]            issue_addr,
    input  logic                             issue_float,
    input  logic [PORT_WIDTH-1:0]            issue_port,
    input  logic [LAT_WIDTH-1:0]             issue_latency,
    output logic [NUM_SRC*DATA_WIDTH-1:0]    fwd_data,
    output logic [NUM_SRC-1:0]               stall,
    output logic                             stall_any,
    output logic                             overrun
);

    // Entry index is {float, addr}; integer register 0 is index 0 and never tracked.
    localparam int IDX_W   = ADDR_WIDTH + 1;
    localparam int NUM_ENT = 2 ** IDX_W;

    logic [NUM_ENT-1:0]    r_busy;
    logic [NUM_ENT-1:0]    r_reported;
    logic [PORT_WIDTH-1:0] r_owner [NUM_ENT];
    logic [LAT_WIDTH-1:0]  r_count [NUM_ENT];
    logic                  r_overrun;

    logic [NUM_ENT-1:0]    w_clear;
    logic [NUM_ENT-1:0]    w_issue_hit;
    logic [NUM_ENT-1:0]    w_overrun_hit;
    logic [IDX_W-1:0]      w_issue_idx;
    logic                  w_issue_ok;

    assign w_issue_idx = {issue_float, issue_addr};
    assign w_issue_ok  = issue_valid && (issue_latency != {LAT_WIDTH{1'b0}})
                         && (w_issue_idx != {IDX_W{1'b0}});

    // One-hot issue target
    always_comb begin
        w_issue_hit              = {NUM_ENT{1'b0}};
        w_issue_hit[w_issue_idx] = w_issue_ok;
    end

    // Owner-port writeback detection per entry; only the owner clears a busy entry
    always_comb begin
        w_clear = {NUM_ENT{1'b0}};
        for (int e = 0; e < NUM_ENT; e++) begin
            for (int p = 0; p < NUM_WB; p++) begin
                w_clear[e] = w_clear[e]
                    | (r_busy[e] && (r_owner[e] == PORT_WIDTH'(p)) && wb_enable[p]
                       && ({wb_float[p], wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} == IDX_W'(e)));
            end
        end
    end

    // Entries that expired without their writeback and have not yet been reported
    always_comb begin
        w_overrun_hit = {NUM_ENT{1'b0}};
        for (int e = 0; e < NUM_ENT; e++) begin
            w_overrun_hit[e] = r_busy[e] && (r_count[e] == {LAT_WIDTH{1'b0}})
                               && !w_clear[e] && !r_reported[e];
        end
    end

    // Scoreboard state: issue beats clear, countdown saturates at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= {NUM_ENT{1'b0}};
            r_reported <= {NUM_ENT{1'b0}};
            r_overrun  <= 1'b0;
            for (int e = 0; e < NUM_ENT; e++) begin
                r_owner[e] <= {PORT_WIDTH{1'b0}};
                r_count[e] <= {LAT_WIDTH{1'b0}};
            end
        end else begin
            r_overrun <= |w_overrun_hit;
            for (int e = 0; e < NUM_ENT; e++) begin
                if (w_issue_hit[e]) begin
                    r_busy[e]     <= 1'b1;
                    r_owner[e]    <= issue_port;
                    r_count[e]    <= issue_latency;
                    r_reported[e] <= 1'b0;
                end else if (w_clear[e]) begin
                    r_busy[e]     <= 1'b0;
                    r_count[e]    <= {LAT_WIDTH{1'b0}};
                    r_reported[e] <= 1'b0;
                end else if (r_busy[e]) begin
                    if (r_count[e] != {LAT_WIDTH{1'b0}}) begin
                        r_count[e] <= r_count[e] - LAT_WIDTH'(1);
                    end else begin
                        r_count[e] <= r_count[e];
                    end
                    r_reported[e] <= r_reported[e] | w_overrun_hit[e];
                end else begin
                    r_busy[e] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        logic [IDX_W-1:0]      w_idx;
        logic                  w_zero;
        logic [DATA_WIDTH-1:0] w_lane_fwd;

        assign w_idx  = {src_float[g], src_addr[g*ADDR_WIDTH +: ADDR_WIDTH]};
        assign w_zero = (w_idx == {IDX_W{1'b0}});

        // Walk ports from highest to lowest index so port 0 wins
        always_comb begin
            w_lane_fwd = src_data[g*DATA_WIDTH +: DATA_WIDTH];
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                w_lane_fwd = (wb_enable[p] && !w_zero
                              && ({wb_float[p], wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH]} == w_idx))
                             ? wb_data[p*DATA_WIDTH +: DATA_WIDTH] : w_lane_fwd;
            end
        end

        assign fwd_data[g*DATA_WIDTH +: DATA_WIDTH] = w_lane_fwd;
        assign stall[g] = !w_zero && r_busy[w_idx] && !w_clear[w_idx];
    end

    assign stall_any = |stall;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard: directed scenarios followed by
// randomized traffic checked against a register-level behavioural model.
module tb_forwarding_scoreboard;

    localparam int NS = 2;
    localparam int NW = 4;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LW = 4;
    localparam int PW = 2;
    localparam int NE = 64;

    logic                clk;
    logic                reset;
    logic [NS*AW-1:0]    src_addr;
    logic [NS-1:0]       src_float;
    logic [NS*DW-1:0]    src_data;
    logic [NW-1:0]       wb_enable;
    logic [NW*AW-1:0]    wb_addr;
    logic [NW-1:0]       wb_float;
    logic [NW*DW-1:0]    wb_data;
    logic                issue_valid;
    logic [AW-1:0]       issue_addr;
    logic                issue_float;
    logic [PW-1:0]       issue_port;
    logic [LW-1:0]       issue_latency;
    logic [NS*DW-1:0]    fwd_data;
    logic [NS-1:0]       stall;
    logic                stall_any;
    logic                overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-register outstanding writes
    bit m_busy [NE];
    int m_owner[NE];
    int m_rem  [NE];
    bit m_rep  [NE];
    bit m_ovf;

    forwarding_scoreboard #(
        .NUM_SRC(NS), .NUM_WB(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .LAT_WIDTH(LW), .PORT_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset),
        .src_addr(src_addr), .src_float(src_float), .src_data(src_data),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_float(wb_float), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_float(issue_float),
        .issue_port(issue_port), .issue_latency(issue_latency),
        .fwd_data(fwd_data), .stall(stall), .stall_any(stall_any), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        src_addr = '0; src_float = '0; src_data = '0;
        wb_enable = '0; wb_addr = '0; wb_float = '0; wb_data = '0;
        issue_valid = 1'b0; issue_addr = '0; issue_float = 1'b0;
        issue_port = '0; issue_latency = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_lane(input int i, input bit f, input int a, input logic [DW-1:0] d);
        src_float[i] = f;
        src_addr[i*AW +: AW] = AW'(a);
        src_data[i*DW +: DW] = d;
    endtask

    task automatic set_wb(input int p, input bit en, input bit f, input int a, input logic [DW-1:0] d);
        wb_enable[p] = en;
        wb_float[p] = f;
        wb_addr[p*AW +: AW] = AW'(a);
        wb_data[p*DW +: DW] = d;
    endtask

    task automatic set_issue(input bit v, input bit f, input int a, input int port, input int lat);
        issue_valid = v;
        issue_float = f;
        issue_addr = AW'(a);
        issue_port = PW'(port);
        issue_latency = LW'(lat);
    endtask

    function automatic logic [DW-1:0] exp_fwd(input int i);
        int a = int'(src_addr[i*AW +: AW]);
        bit f = src_float[i];
        if (!f && a == 0) return src_data[i*DW +: DW];
        for (int p = 0; p < NW; p++) begin
            if (wb_enable[p] && wb_float[p] == f && int'(wb_addr[p*AW +: AW]) == a)
                return wb_data[p*DW +: DW];
        end
        return src_data[i*DW +: DW];
    endfunction

    function automatic bit owner_writes(input int e);
        int o = m_owner[e];
        return wb_enable[o] && (int'(wb_float[o]) * 32 + int'(wb_addr[o*AW +: AW]) == e);
    endfunction

    function automatic bit exp_stall(input int i);
        int e = int'(src_float[i]) * 32 + int'(src_addr[i*AW +: AW]);
        if (e == 0 || !m_busy[e]) return 1'b0;
        return !owner_writes(e);
    endfunction

    task automatic model_step();
        bit nov = 1'b0;
        int ie;
        if (reset) begin
            foreach (m_busy[e]) begin
                m_busy[e] = 1'b0; m_owner[e] = 0; m_rem[e] = 0; m_rep[e] = 1'b0;
            end
            m_ovf = 1'b0;
            return;
        end
        ie = int'(issue_float) * 32 + int'(issue_addr);
        for (int e = 0; e < NE; e++) begin
            if (m_busy[e]) begin
                if (owner_writes(e)) begin
                    m_busy[e] = 1'b0;
                    m_rep[e] = 1'b0;
                end else begin
                    if (m_rem[e] == 0 && !m_rep[e]) begin
                        nov = 1'b1;
                        m_rep[e] = 1'b1;
                    end
                    if (m_rem[e] > 0) m_rem[e] = m_rem[e] - 1;
                end
            end
        end
        if (issue_valid && issue_latency != 0 && ie != 0) begin
            m_busy[ie] = 1'b1;
            m_owner[ie] = int'(issue_port);
            m_rem[ie] = int'(issue_latency);
            m_rep[ie] = 1'b0;
        end
        m_ovf = nov;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_issue(1'b1, 1'b0, 12, 1, 5);
        tick();
        reset = 1'b0;
        idle();
        set_lane(0, 1'b0, 12, 32'h0000_00C0);
        #1;
        n_tests++;
        if (stall !== 2'b00) begin
            n_fail++; $display("FAIL reset_stall: got %b expected %b", stall, 2'b00);
        end
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL reset_overrun: got %b expected %b", overrun, 1'b0);
        end
        n_tests++;
        if (fwd_data[31:0] !== 32'h0000_00C0) begin
            n_fail++; $display("FAIL reset_fwd: got %h expected %h", fwd_data[31:0], 32'h0000_00C0);
        end
        tick();
    endtask

    task automatic test_float_forward();
        do_reset();
        set_wb(2, 1'b1, 1'b1, 3, 32'h3F80_0000);
        set_lane(0, 1'b1, 3, 32'h0);
        #1;
        n_tests++;
        if (fwd_data[31:0] !== 32'h3F80_0000 || stall[0] !== 1'b0) begin
            n_fail++; $display("FAIL float_fwd: got %h/%b expected %h/0", fwd_data[31:0], stall[0], 32'h3F80_0000);
        end
        tick();
    endtask

    task automatic test_alias();
        do_reset();
        set_wb(0, 1'b1, 1'b0, 3, 32'h11);
        set_wb(1, 1'b1, 1'b0, 3, 32'h22);
        set_lane(0, 1'b0, 3, 32'hAA);
        set_lane(1, 1'b1, 3, 32'hBB);
        #1;
        n_tests++;
        if (fwd_data[31:0] !== 32'h11) begin
            n_fail++; $display("FAIL alias_prio: got %h expected %h", fwd_data[31:0], 32'h11);
        end
        n_tests++;
        if (fwd_data[63:32] !== 32'hBB) begin
            n_fail++; $display("FAIL alias_space: got %h expected %h", fwd_data[63:32], 32'hBB);
        end
        tick();
    endtask

    task automatic test_issue_stall();
        do_reset();
        set_issue(1'b1, 1'b1, 5, 3, 3);
        tick();
        idle();
        set_lane(0, 1'b1, 5, 32'h55);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (stall[0] !== 1'b1 || stall_any !== 1'b1) begin
                n_fail++; $display("FAIL issue_stall[%0d]: got %b/%b expected 1/1", k, stall[0], stall_any);
            end
            tick();
        end
        set_wb(3, 1'b1, 1'b1, 5, 32'hABCD);
        #1;
        n_tests++;
        if (fwd_data[31:0] !== 32'hABCD || stall[0] !== 1'b0 || stall_any !== 1'b0) begin
            n_fail++; $display("FAIL issue_wb: got %h/%b/%b expected %h/0/0", fwd_data[31:0], stall[0], stall_any, 32'hABCD);
        end
        tick();
        set_wb(3, 1'b0, 1'b0, 0, 32'h0);
        set_lane(0, 1'b1, 5, 32'h1234);
        #1;
        n_tests++;
        if (fwd_data[31:0] !== 32'h1234 || stall[0] !== 1'b0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL issue_after: got %h/%b/%b expected %h/0/0", fwd_data[31:0], stall[0], overrun, 32'h1234);
        end
        tick();
    endtask

    task automatic test_non_owner();
        do_reset();
        set_issue(1'b1, 1'b0, 7, 1, 8);
        tick();
        idle();
        set_lane(0, 1'b0, 7, 32'h0);
        set_wb(0, 1'b1, 1'b0, 7, 32'h5);
        #1;
        n_tests++;
        if (fwd_data[31:0] !== 32'h5 || stall[0] !== 1'b1) begin
            n_fail++; $display("FAIL nonowner_fwd: got %h/%b expected 5/1", fwd_data[31:0], stall[0]);
        end
        tick();
        set_wb(0, 1'b0, 1'b0, 0, 32'h0);
        #1;
        n_tests++;
        if (stall[0] !== 1'b1) begin
            n_fail++; $display("FAIL nonowner_hold: got %b expected 1", stall[0]);
        end
        tick();
        set_wb(0, 1'b1, 1'b0, 7, 32'h5);
        set_wb(1, 1'b1, 1'b0, 7, 32'h9);
        #1;
        n_tests++;
        if (fwd_data[31:0] !== 32'h5 || stall[0] !== 1'b0) begin
            n_fail++; $display("FAIL owner_clear: got %h/%b expected 5/0", fwd_data[31:0], stall[0]);
        end
        tick();
        idle();
        set_lane(0, 1'b0, 7, 32'h0);
        #1;
        n_tests++;
        if (stall[0] !== 1'b0) begin
            n_fail++; $display("FAIL owner_cleared: got %b expected 0", stall[0]);
        end
        tick();
    endtask

    task automatic test_overrun();
        do_reset();
        set_issue(1'b1, 1'b0, 9, 0, 2);
        tick();
        idle();
        set_lane(0, 1'b0, 9, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_tests++;
            if (overrun !== (k == 3) || stall[0] !== 1'b1) begin
                n_fail++; $display("FAIL overrun[%0d]: got %b/%b expected %b/1", k, overrun, stall[0], (k == 3));
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (stall[0] !== 1'b0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun_reset: got %b/%b expected 0/0", stall[0], overrun);
        end
        tick();
    endtask

    task automatic test_r0();
        do_reset();
        set_issue(1'b1, 1'b0, 0, 0, 4);
        set_wb(0, 1'b1, 1'b0, 0, 32'hFFFF);
        set_lane(0, 1'b0, 0, 32'h0);
        set_lane(1, 1'b0, 0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            n_tests++;
            if (fwd_data !== 64'h0 || stall !== 2'b00 || overrun !== 1'b0) begin
                n_fail++; $display("FAIL r0[%0d]: got %h/%b/%b expected 0/00/0", k, fwd_data, stall, overrun);
            end
            tick();
        end
    endtask

    task automatic test_reload_and_lat0();
        do_reset();
        set_issue(1'b1, 1'b0, 11, 2, 5);
        tick();
        idle();
        set_issue(1'b1, 1'b0, 11, 1, 5);
        set_wb(2, 1'b1, 1'b0, 11, 32'h7);
        set_lane(0, 1'b0, 11, 32'h0);
        #1;
        n_tests++;
        if (stall[0] !== 1'b0) begin
            n_fail++; $display("FAIL reload_bypass: got %b expected 0", stall[0]);
        end
        tick();
        idle();
        set_issue(1'b1, 1'b0, 11, 3, 0);
        set_wb(2, 1'b1, 1'b0, 11, 32'h7);
        set_lane(0, 1'b0, 11, 32'h0);
        #1;
        n_tests++;
        if (stall[0] !== 1'b1) begin
            n_fail++; $display("FAIL reload_owner: got %b expected 1", stall[0]);
        end
        tick();
        idle();
        set_lane(0, 1'b0, 11, 32'h0);
        #1;
        n_tests++;
        if (stall[0] !== 1'b1) begin
            n_fail++; $display("FAIL lat0_keep: got %b expected 1", stall[0]);
        end
        set_wb(1, 1'b1, 1'b0, 11, 32'h8);
        tick();
        idle();
        set_lane(0, 1'b0, 11, 32'h0);
        #1;
        n_tests++;
        if (stall[0] !== 1'b0) begin
            n_fail++; $display("FAIL reload_clear: got %b expected 0", stall[0]);
        end
        tick();
    endtask

    task automatic test_random();
        reset = 1'b1;
        idle();
        model_step();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < NS; i++)
                set_lane(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), DW'($urandom));
            for (int p = 0; p < NW; p++)
                set_wb(p, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), DW'($urandom));
            set_issue(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)));
            #1;
            for (int i = 0; i < NS; i++) begin
                n_tests++;
                if (fwd_data[i*DW +: DW] !== exp_fwd(i) || stall[i] !== exp_stall(i)) begin
                    n_fail++;
                    $display("FAIL rand_lane c=%0d i=%0d: got %h/%b expected %h/%b",
                             c, i, fwd_data[i*DW +: DW], stall[i], exp_fwd(i), exp_stall(i));
                end
            end
            n_tests++;
            if (stall_any !== (exp_stall(0) | exp_stall(1))) begin
                n_fail++; $display("FAIL rand_stall_any c=%0d: got %b", c, stall_any);
            end
            model_step();
            tick();
            n_tests++;
            if (overrun !== m_ovf) begin
                n_fail++; $display("FAIL rand_overrun c=%0d: got %b expected %b", c, overrun, m_ovf);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        test_reset();
        test_float_forward();
        test_alias();
        test_issue_stall();
        test_non_owner();
        test_overrun();
        test_r0();
        test_reload_and_lat0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
